// File: rtl/ov2640_pkg.sv
// Shared OV2640 bring-up types and constants: sequencer states, ROM sizing
// and the registers the init sequence depends on.
package ov2640_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } seq_state_e;

  localparam int unsigned OV_NUM_REGS  = 197;
  localparam int unsigned OV_DELAY_IDX = 1;

  localparam logic [7:0] OV_REG_BANK_SEL = 8'hFF;
  localparam logic [7:0] OV_REG_COM7     = 8'h12;
  localparam logic [7:0] OV_COM7_SRST    = 8'h80;

endpackage

// File: rtl/delay_counter.sv
// One-shot cycle timer: load starts a run of exactly CYCLES cycles, expire_o
// is high on the last one. Shared by soft-reset, power-up and PWDN timing.
module delay_counter #(
  parameter int unsigned CYCLES = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == LAST) run_q <= 1'b0;
      else               cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_o = run_q && (cnt_q == LAST);

endmodule

// File: rtl/ov2640_init_seq.sv
// Walks the OV2640 register ROM, handing each {reg, value} pair to the SCCB
// write master, with the COM7 soft-reset delay and bounded NACK retries.
module ov2640_init_seq
  import ov2640_pkg::*;
#(
  parameter int unsigned NUM_REGS     = OV_NUM_REGS,
  parameter int unsigned DELAY_IDX    = OV_DELAY_IDX,
  parameter int unsigned DELAY_CYCLES = 25000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_reg_addr,
  input  logic [7:0] rom_value,
  output logic       wr_valid,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  input  logic       wr_done,
  input  logic       wr_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] err_idx
);

  if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_num_regs
    $error("ov2640_init_seq: NUM_REGS must be 1..256");
  end
  if (DELAY_IDX >= NUM_REGS || MAX_RETRY < 1) begin : g_bad_cfg
    $error("ov2640_init_seq: DELAY_IDX must index the ROM and MAX_RETRY >= 1");
  end

  localparam int unsigned RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [7:0]    LAST_IDX   = 8'(NUM_REGS - 1);
  localparam logic [7:0]    DLY_IDX    = 8'(DELAY_IDX);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  seq_state_e    state_q;
  logic [7:0]    idx_q, rom_addr_q, wr_reg_q, wr_data_q, err_idx_q;
  logic [RW-1:0] retry_q;
  logic          wr_valid_q, busy_q, done_q, error_q;
  logic          dly_load, dly_expire;

  assign dly_load = (state_q == ST_WAIT_DONE) && wr_done && !wr_nack && (idx_q == DLY_IDX);

  delay_counter #(.CYCLES(DELAY_CYCLES)) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (dly_load),
    .expire_o (dly_expire)
  );

  // rom_addr is loaded as FETCH is entered so the ROM's registered output is
  // already settled during FETCH_WAIT and can be captured on entry to ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rom_addr_q <= '0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      retry_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_q    <= ST_FETCH;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_idx_q  <= '0;
            idx_q      <= '0;
            rom_addr_q <= '0;
            retry_q    <= '0;
          end
        end
        ST_FETCH: begin
          rom_addr_q <= idx_q;
          state_q    <= ST_FETCH_WAIT;
        end
        ST_FETCH_WAIT: begin
          wr_reg_q   <= rom_reg_addr;
          wr_data_q  <= rom_value;
          wr_valid_q <= 1'b1;
          state_q    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (wr_ready) begin
            wr_valid_q <= 1'b0;
            state_q    <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (wr_done) begin
            if (!wr_nack) begin
              retry_q <= '0;
              state_q <= (idx_q == DLY_IDX) ? ST_DELAY : ST_NEXT;
            end else if (retry_q == RETRY_LAST) begin
              err_idx_q <= idx_q;
              error_q   <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= ST_ERROR;
            end else begin
              // retry replays the captured pair without refetching the ROM
              retry_q    <= retry_q + RW'(1);
              wr_valid_q <= 1'b1;
              state_q    <= ST_ISSUE;
            end
          end
        end
        ST_DELAY: begin
          if (dly_expire) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            idx_q      <= idx_q + 8'd1;
            rom_addr_q <= idx_q + 8'd1;
            state_q    <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign wr_valid = wr_valid_q;
  assign wr_reg   = wr_reg_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_ov2640_init_seq.sv
// Directed bench: registered ROM model plus an SCCB master model with
// scripted backpressure and NACKs, all stepped once per clock from one process.
module tb_ov2640_init_seq;

  logic       clk, rst_n, start;
  logic [7:0] rom_addr, rom_reg_addr, rom_value;
  logic       wr_valid, wr_ready, wr_done, wr_nack;
  logic [7:0] wr_reg, wr_data, err_idx;
  logic       busy, done, error;

  ov2640_init_seq #(
    .NUM_REGS(197), .DELAY_IDX(1), .DELAY_CYCLES(100), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_reg_addr(rom_reg_addr), .rom_value(rom_value),
    .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_done(wr_done), .wr_nack(wr_nack),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input int i);
    logic [7:0] a, v;
    case (i)
      0:       return 16'hFF01;
      1:       return 16'h1280;
      196:     return 16'h0500;
      default: begin
        a = 8'(i) ^ 8'h3C;
        v = 8'(i * 7 + 1);
        return {a, v};
      end
    endcase
  endfunction

  always @(posedge clk) {rom_reg_addr, rom_value} <= rom_word(int'(rom_addr));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // model state
  int ack_cnt, xfers, pend, rises, tick_n, done_tick;
  int bp_entry, bp_len, bp_cnt, nack_entry, nack_times, nack_given;
  bit pend_nack, vld_prev, gap_chk;
  int xfer_cnt [0:255];
  logic [15:0] xlog [0:511];

  task automatic tick();
    @(negedge clk);
    tick_n++;
    wr_done = 1'b0;
    wr_nack = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        wr_done   = 1'b1;
        wr_nack   = pend_nack;
        done_tick = tick_n;
        if (!pend_nack) ack_cnt++;
      end
    end
    if (wr_valid && !vld_prev) begin
      rises++;
      if (gap_chk && ack_cnt > 0)
        chk("gap", tick_n - done_tick, (ack_cnt - 1 == 1) ? 104 : 4);
    end
    vld_prev = wr_valid;
    if (wr_valid && ack_cnt == bp_entry && bp_cnt < bp_len) begin
      wr_ready = 1'b0;
      bp_cnt++;
      chk("bp_stable", {wr_reg, wr_data}, rom_word(bp_entry));
    end else begin
      wr_ready = 1'b1;
    end
    if (wr_valid && wr_ready) begin
      chk("xfer", {wr_reg, wr_data}, rom_word(ack_cnt));
      if (xfers < 512) xlog[xfers] = {wr_reg, wr_data};
      xfers++;
      xfer_cnt[ack_cnt]++;
      pend      = 5;
      pend_nack = (ack_cnt == nack_entry) && (nack_given < nack_times);
      if (pend_nack) nack_given++;
    end
  endtask

  task automatic setup(input int bpe, input int bpl, input int ne, input int nn, input bit g);
    ack_cnt = 0; xfers = 0; pend = 0; pend_nack = 0; bp_cnt = 0; nack_given = 0;
    bp_entry = bpe; bp_len = bpl; nack_entry = ne; nack_times = nn; gap_chk = g;
    for (int i = 0; i < 256; i++) xfer_cnt[i] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && !(done || error); i++) tick();
    if (!(done || error)) chk("seq_timeout", 0, 1);
  endtask

  initial begin
    int r0;
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
    tick_n = 0; rises = 0; done_tick = 0; vld_prev = 0; gap_chk = 0;
    ack_cnt = 0; xfers = 0; pend = 0; pend_nack = 0;
    bp_entry = -1; bp_len = 0; bp_cnt = 0; nack_entry = -1; nack_times = 0; nack_given = 0;
    repeat (3) tick();
    chk("rst_outs", {wr_valid, busy, done, error}, 4'b0000);
    chk("rst_addr", {rom_addr, err_idx}, 16'h0000);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", busy, 0);

    // nominal run with soft-reset gap measurement
    setup(-1, 0, -1, 0, 1'b1);
    chk("start_busy", busy, 1);
    wait_end(5000);
    chk("a_xfers", xfers, 197);
    chk("a_first", xlog[0], 16'hFF01);
    chk("a_second", xlog[1], 16'h1280);
    chk("a_last", xlog[196], 16'h0500);
    chk("a_flags", {done, busy, error}, 3'b100);

    // backpressure on entry 5, two NACKs on entry 20
    setup(5, 10, 20, 2, 1'b0);
    wait_end(5000);
    chk("b_bp_cycles", bp_cnt, 10);
    chk("b_e5_xfers", xfer_cnt[5], 1);
    chk("b_e20_xfers", xfer_cnt[20], 3);
    chk("b_xfers", xfers, 199);
    chk("b_flags", {done, busy, error}, 3'b100);

    // three NACKs on entry 40 abort the sequence
    setup(-1, 0, 40, 3, 1'b0);
    wait_end(5000);
    chk("c_flags", {done, busy, error}, 3'b001);
    chk("c_err_idx", err_idx, 40);
    chk("c_xfers", xfers, 43);
    r0 = rises;
    repeat (50) tick();
    chk("c_quiet", rises - r0, 0);

    // restart from ERROR, then async reset while entry 50 is stalled
    setup(50, 100000, -1, 0, 1'b0);
    chk("d_err_clr", error, 0);
    for (int i = 0; i < 3000 && !(wr_valid && ack_cnt == 50); i++) tick();
    chk("d_reach50", {wr_valid, 8'(ack_cnt)}, {1'b1, 8'd50});
    chk("d_first", xlog[0], 16'hFF01);
    rst_n = 1'b0;
    #1;
    chk("d_rst_now", {wr_valid, busy}, 2'b00);
    chk("d_rst_addr", rom_addr, 0);
    pend = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    r0 = rises;
    repeat (20) tick();
    chk("d_idle", {wr_valid, busy, done, error}, 4'b0000);
    chk("d_quiet", rises - r0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
